// File: rtl/ht_pkg.sv
// ht_pkg: shared constants, symbol indices, FSM state and code-table entry type
// for the serial Huffman decoder.
package ht_pkg;

    localparam int NUM_SYM    = 8;
    localparam int MAX_LEN    = 7;
    localparam int FRAME_SYMS = 5;

    localparam logic [2:0] SYM_A = 3'd0;
    localparam logic [2:0] SYM_B = 3'd1;
    localparam logic [2:0] SYM_C = 3'd2;
    localparam logic [2:0] SYM_E = 3'd3;
    localparam logic [2:0] SYM_I = 3'd4;
    localparam logic [2:0] SYM_L = 3'd5;
    localparam logic [2:0] SYM_O = 3'd6;
    localparam logic [2:0] SYM_V = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    // len == 0 marks an unused symbol; code is right-aligned in [len-1:0]
    typedef struct packed {
        logic [2:0] len;
        logic [6:0] code;
    } tbl_entry_t;

endpackage

// File: rtl/ht_match.sv
// ht_match: combinational codeword lookup against the 8-entry code table.
//   i_tbl  : code table entries
//   i_cand : candidate bits, right-aligned, upper bits zero
//   i_len  : candidate length in bits
//   o_hit  : some entry matches length and code
//   o_sym  : lowest matching entry index (0 when no hit)
module ht_match
    import ht_pkg::*;
(
    input  tbl_entry_t i_tbl [NUM_SYM],
    input  logic [6:0] i_cand,
    input  logic [2:0] i_len,
    output logic       o_hit,
    output logic [2:0] o_sym
);

    logic [6:0] w_mask;

    // Bits above the codeword length are don't-care in the stored code
    assign w_mask = ~(7'h7f << i_len);

    // Descending scan so the lowest matching index is written last and wins
    always_comb begin
        o_hit = 1'b0;
        o_sym = 3'd0;
        for (int k = NUM_SYM - 1; k >= 0; k--) begin
            if (i_tbl[k].len == i_len && (i_tbl[k].code & w_mask) == i_cand) begin
                o_hit = 1'b1;
                o_sym = 3'(k);
            end
        end
    end

endmodule

// File: rtl/ht_decoder.sv
// ht_decoder: serial Huffman bitstream decoder; loads an 8-entry code table,
// then turns a 1-bit code stream into 3-bit symbol indices, framed in groups.
//   clk, rst_n           : clock, asynchronous active-low reset
//   tbl_valid/len/code   : one table entry per qualified cycle (IDLE/LOAD only)
//   in_valid/in_code     : serial code bits, first-transmitted bit first (DECODE only)
//   out_valid/out_sym    : registered one-cycle pulse per decoded symbol
//   out_last             : marks the final symbol of a frame
//   out_err              : registered pulse on an undecodable codeword
module ht_decoder
    import ht_pkg::*;
#(
    parameter int FRAME_SYMS = ht_pkg::FRAME_SYMS,
    parameter int MAX_LEN    = ht_pkg::MAX_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tbl_valid,
    input  logic [2:0] tbl_len,
    input  logic [6:0] tbl_code,
    input  logic       in_valid,
    input  logic       in_code,
    output logic       out_valid,
    output logic [2:0] out_sym,
    output logic       out_last,
    output logic       out_err
);

    localparam logic [2:0] LAST_SYM = 3'(FRAME_SYMS - 1);
    localparam logic [2:0] LEN_MAX  = 3'(MAX_LEN);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [2:0] r_cnt;
    logic [2:0] r_symcnt;
    logic [5:0] r_acc;
    tbl_entry_t r_tbl [NUM_SYM];

    tbl_entry_t w_entry;
    logic [6:0] w_cand;
    logic [2:0] w_len;
    logic       w_hit;
    logic [2:0] w_sym;

    assign w_entry = '{len: tbl_len, code: tbl_code};
    // acc holds at most MAX_LEN-1 bits, so the candidate's upper bits stay zero
    assign w_cand  = {r_acc, in_code};
    assign w_len   = r_cnt + 3'd1;

    ht_match u_match (
        .i_tbl  (r_tbl),
        .i_cand (w_cand),
        .i_len  (w_len),
        .o_hit  (w_hit),
        .o_sym  (w_sym)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= 3'd0;
            r_cnt     <= 3'd0;
            r_symcnt  <= 3'd0;
            r_acc     <= 6'd0;
            for (int k = 0; k < NUM_SYM; k++) r_tbl[k] <= '0;
            out_valid <= 1'b0;
            out_sym   <= 3'd0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sym   <= 3'd0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tbl_valid) begin
                        r_tbl[0] <= w_entry;
                        r_idx    <= 3'd1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (tbl_valid) begin
                        r_tbl[r_idx] <= w_entry;
                        r_idx        <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (in_valid) begin
                        if (w_hit) begin
                            out_valid <= 1'b1;
                            out_sym   <= w_sym;
                            r_acc     <= 6'd0;
                            r_cnt     <= 3'd0;
                            if (r_symcnt == LAST_SYM) begin
                                out_last <= 1'b1;
                                r_symcnt <= 3'd0;
                                r_state  <= ST_IDLE;
                            end else begin
                                r_symcnt <= r_symcnt + 3'd1;
                            end
                        end else if (w_len == LEN_MAX) begin
                            // Longest possible codeword still unmatched: abort the frame
                            out_err  <= 1'b1;
                            r_acc    <= 6'd0;
                            r_cnt    <= 3'd0;
                            r_symcnt <= 3'd0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_acc <= w_cand[5:0];
                            r_cnt <= w_len;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ht_decoder.sv
// tb_ht_decoder: scoreboard bench for ht_decoder; expected symbols are queued
// with their due cycle as codewords are driven and checked as outputs appear.
module tb_ht_decoder;

    typedef struct {
        int due;
        int sym;
        int last;
        int err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tbl_valid = 1'b0;
    logic [2:0] tbl_len = 3'd0;
    logic [6:0] tbl_code = 7'd0;
    logic       in_valid = 1'b0;
    logic       in_code = 1'b0;
    logic       out_valid;
    logic [2:0] out_sym;
    logic       out_last;
    logic       out_err;

    int         n_vec = 0;
    int         n_bad = 0;
    int         n_neg = 0;
    exp_t       sb[$];
    exp_t       e_m;
    logic [2:0] t_len [8];
    logic [6:0] t_code [8];

    ht_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tbl_valid (tbl_valid),
        .tbl_len   (tbl_len),
        .tbl_code  (tbl_code),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_sym   (out_sym),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled mid-cycle; each pulse must match the queue head exactly on its due cycle
    always @(negedge clk) begin
        n_neg++;
        if (out_valid || out_err) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {out_valid, out_err, out_sym, out_last}, 0);
            end else begin
                e_m = sb.pop_front();
                chk("due_cycle", n_neg, e_m.due);
                chk("sym", int'(out_sym), e_m.sym);
                chk("last", int'(out_last), e_m.last);
                chk("err", int'(out_err), e_m.err);
                chk("valid", int'(out_valid), 1 - e_m.err);
            end
        end else begin
            chk("quiet_outs", {out_sym, out_last}, 0);
            if (sb.size() > 0 && sb[0].due < n_neg) begin
                e_m = sb.pop_front();
                chk("missed_pulse", n_neg, e_m.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sym, input int last, input int err);
        sb.push_back('{due: n_neg + 1, sym: sym, last: last, err: err});
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        in_code  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic cw(input logic [6:0] code, input int len, input int sym, input int last);
        for (int i = len - 1; i >= 0; i--) send(code[i]);
        push(sym, last, 0);
    endtask

    // noise drives decodable bits during the load; they must be ignored
    task automatic load(input int gap3, input bit noise);
        for (int k = 0; k < 8; k++) begin
            tbl_valid = 1'b1;
            tbl_len   = t_len[k];
            tbl_code  = t_code[k];
            in_valid  = noise;
            in_code   = 1'b0;
            tick();
            tbl_valid = 1'b0;
            if (k == 3) repeat (gap3) tick();
        end
        in_valid = 1'b0;
    endtask

    function automatic void set_t();
        t_len[0] = 3'd4; t_code[0] = 7'h0e;
        t_len[1] = 3'd5; t_code[1] = 7'h1e;
        t_len[2] = 3'd5; t_code[2] = 7'h1f;
        t_len[3] = 3'd3; t_code[3] = 7'h06;
        t_len[4] = 3'd2; t_code[4] = 7'h00;
        t_len[5] = 3'd2; t_code[5] = 7'h01;
        t_len[6] = 3'd3; t_code[6] = 7'h04;
        t_len[7] = 3'd3; t_code[7] = 7'h05;
    endfunction

    function automatic void clr_t();
        for (int k = 0; k < 8; k++) begin
            t_len[k]  = 3'd0;
            t_code[k] = 7'h00;
        end
    endfunction

    task automatic ilove();
        cw(7'h00, 2, 4, 0);
        cw(7'h01, 2, 5, 0);
        cw(7'h04, 3, 6, 0);
        cw(7'h05, 3, 7, 0);
        cw(7'h06, 3, 3, 1);
    endtask

    task automatic pulse_rst();
        rst_n = 1'b0;
        #1;
        chk("rst_outs", {out_valid, out_sym, out_last, out_err}, 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        pulse_rst();
        tick();

        // ILOVE, then bits in IDLE after the frame must be ignored
        set_t();
        load(0, 0);
        ilove();
        send(1'b0);
        send(1'b0);
        tick();

        // ICLAB with a two-cycle gap inside C
        load(0, 0);
        cw(7'h00, 2, 4, 0);
        send(1'b1); send(1'b1); send(1'b1);
        repeat (2) tick();
        send(1'b1); send(1'b1);
        push(2, 0, 0);
        cw(7'h01, 2, 5, 0);
        cw(7'h0e, 4, 0, 0);
        cw(7'h1e, 5, 1, 1);
        tick();

        // Undecodable 7-bit run aborts to IDLE; the following bit is ignored
        set_t();
        t_len[2] = 3'd0;
        load(0, 0);
        repeat (7) send(1'b1);
        push(0, 0, 1);
        send(1'b0);
        repeat (2) tick();

        // Load with a gap and bit noise, then ILOVE
        set_t();
        load(3, 1);
        ilove();
        repeat (2) tick();

        // Back-to-back 1-bit codes, a full 7-bit codeword, ignored upper code bits
        clr_t();
        t_len[0] = 3'd1; t_code[0] = 7'h54;
        t_len[1] = 3'd2; t_code[1] = 7'h02;
        t_len[2] = 3'd7; t_code[2] = 7'h7f;
        load(0, 0);
        cw(t_code[0], 1, 0, 0);
        cw(t_code[0], 1, 0, 0);
        cw(7'h02, 2, 1, 0);
        cw(7'h7f, 7, 2, 0);
        cw(t_code[0], 1, 0, 1);
        repeat (2) tick();

        // Reset mid-codeword must not leave a stale accumulator
        set_t();
        load(0, 0);
        send(1'b1);
        send(1'b1);
        pulse_rst();
        load(0, 0);
        cw(7'h00, 2, 4, 0);
        // Reset landing on a live pulse clears it immediately
        send(1'b0);
        send(1'b1);
        chk("pulse_before_rst", {out_valid, out_sym}, {1'b1, 3'd5});
        pulse_rst();
        tick();

        // Lowest index wins on duplicate codewords
        clr_t();
        t_len[0] = 3'd2; t_code[0] = 7'h00;
        t_len[4] = 3'd2; t_code[4] = 7'h00;
        load(0, 0);
        cw(7'h00, 2, 0, 0);
        repeat (4) tick();

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ht_decoder.md
# ht_decoder

Serial Huffman bitstream decoder: the receive-side counterpart of the HT_TOP encoder core. Loads an 8-symbol code table, then consumes the 1-bit `in_code` stream qualified by `in_valid` (the same signalling HT_TOP drives on `out_valid`/`out_code`). It emits one 3-bit symbol index per completed codeword and flags the last symbol of each frame. Sits in the core behind input pads, as the loop-back/checker path for the encoder.

## Interface
- `FRAME_SYMS`, default 5: symbols per frame.
- `MAX_LEN`, default 7: maximum codeword length in bits.
- `clk` input, 1 bit: single clock, all state on rising edge.
- `rst_n` input, 1 bit: reset is asynchronous and active-low.
- `tbl_valid` input, 1 bit: qualifies one table entry per cycle.
- `tbl_len` input, 3 bits: codeword length 0..7; 0 = symbol unused.
- `tbl_code` input, 7 bits: codeword right-aligned in `[len-1:0]`, with the first transmitted bit at `[len-1]`; upper bits ignored.
- `in_valid` input, 1 bit: qualifies `in_code`.
- `in_code` input, 1 bit: serial code bit, MSB (root-level bit) first.
- `out_valid` output, 1 bit: one-cycle pulse per decoded symbol.
- `out_sym` output, 3 bits: symbol index A=0 B=1 C=2 E=3 I=4 L=5 O=6 V=7; 0 when `out_valid`=0.
- `out_last` output, 1 bit: high with the `FRAME_SYMS`-th `out_valid`.
- `out_err` output, 1 bit: one-cycle pulse on an undecodable codeword.

## Operation
- States:
  - **IDLE**: `tbl_valid` captures entry 0, sets idx=1 → LOAD.
  - **LOAD**:
    - `tbl_valid` captures entry idx and increments idx; capture of entry 7 → DECODE.
    - `tbl_valid`=0 holds state and idx (gaps allowed).
  - **DECODE**: consumes bits.
  - `in_valid`/`in_code` are ignored in IDLE and LOAD; `tbl_*` is ignored in DECODE.
- DECODE, per cycle with `in_valid`=1:
  - Candidate = {acc, in_code}, length cnt+1.
  - Entry k matches when `tbl_len[k]`==cnt+1 and `tbl_code[k][cnt:0]`==candidate.
  - If several entries match (non-prefix-free table), the lowest k wins.
  - Match: register `out_valid`=1 and `out_sym`=k; clear acc/cnt; increment symcnt.
  - No match and cnt+1 < `MAX_LEN`: acc ← candidate, cnt ← cnt+1.
  - No match and cnt+1 == `MAX_LEN`: `out_err`=1, clear acc/cnt/symcnt → IDLE (frame aborted).
- `in_valid`=0 in DECODE: acc, cnt and symcnt hold; gaps mid-codeword are legal.
- Match with symcnt == `FRAME_SYMS`-1: `out_last`=1 together with `out_valid`; symcnt clears → IDLE.
- The table is retained in IDLE but is fully overwritten by the next load. A new frame always requires a full 8-entry reload.
- Reset (any time, including mid-load or mid-codeword): state IDLE; idx, acc, cnt, symcnt = 0; all `tbl_len` = 0; all outputs 0.

## Timing
- All outputs are registered.
- Latency: the bit completing a codeword is sampled at edge t; `out_valid`/`out_sym` are high for the cycle after t and drop the following cycle unless another match occurs.
- Back-to-back 1-bit codewords give `out_valid` high on consecutive cycles.
- `out_err` has the same 1-cycle latency, relative to the 7th unmatched bit.
- First decodable bit: the cycle after the entry-7 capture edge.
- Throughput: 1 bit per cycle, no backpressure.
- Entering DECODE from LOAD and returning to IDLE take effect at the clock edge; the bit sampled on that edge belongs to the old state.

## Structure
- Shared package `ht_pkg`:
  - constants `NUM_SYM`=8, `MAX_LEN`=7, `FRAME_SYMS`=5;
  - symbol index constants A..V;
  - state enum {IDLE, LOAD, DECODE};
  - table-entry struct {len[2:0], code[6:0]}.
- Sub-module `ht_match`: combinational. Takes the 8 entries, the candidate and the candidate length; returns `hit` and a priority-encoded `sym`.

## Test plan
Table T used below: I=00, L=01, O=100, V=101, E=110, A=1110, B=11110, C=11111.
- **ILOVE**: load T, stream 0001100101110 continuously → `out_sym` 4,5,6,7,3 on five pulses; `out_last` with 3.
- **ICLAB with gaps**: load T, stream 00 11111 01 1110 11110 with `in_valid` low 2 cycles inside C → `out_sym` 4,2,5,0,1; timing shifts only by the gap.
- **Error**: load T with C len 0, stream 1111111 → no `out_valid`; `out_err` pulse the cycle after the 7th bit; state returns to IDLE, and a following bit 0 produces nothing.
- **Load gaps**: `tbl_valid` with 3 idle cycles between entries 3 and 4, plus bits driven during LOAD → bits ignored; a subsequent ILOVE decodes correctly.
- **Mid-codeword reset**: stream 11, assert `rst_n`=0 one cycle → all outputs 0 immediately; after reload, 00 decodes to I (no stale acc).
- **Priority**: table with entries A and I both len 2 code 00 → 00 decodes to 0.
